// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   drain_state_t      : state encoding of the FIFO drain FSM
//   CLK_PER_HALF_BIT   : default half-bit period (clocks) of the byte transmitter
//   DEFAULT_DEPTH_LOG2 : default log2 FIFO depth of uart_tx_fifo
package uart_pkg;

  localparam int CLK_PER_HALF_BIT   = 4;
  localparam int DEFAULT_DEPTH_LOG2 = 9;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } drain_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port byte RAM with a registered read port (BRAM friendly).
// Ports:
//   clk   : clock
//   rstn  : synchronous active-low reset, clears only the read register
//   we    : write enable
//   waddr : write address
//   wdata : write byte
//   re    : read enable; rdata is loaded with mem[raddr] and otherwise held
//   raddr : read address
//   rdata : registered read byte
module uart_fifo_mem #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register doubles as the byte presented to the transmitter, so
  // it only updates on a pop and holds otherwise.
  always_ff @(posedge clk) begin
    if (!rstn)   rdata <= 8'h00;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit-side FIFO in front of a byte-level UART transmitter.
// Bytes are pushed at full clock rate into a circular buffer; a drain FSM
// pops one byte at a time and issues one tx_start pulse per byte, waiting for
// the transmitter's tx_busy to rise and fall before the next pop.
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   wr_data   : byte to enqueue
//   wr_en     : enqueue strobe (one byte per cycle)
//   full      : FIFO holds DEPTH bytes
//   empty     : FIFO holds 0 bytes
//   count     : current occupancy
//   overflow  : sticky, set when a write is dropped because the FIFO is full
//   sdata     : byte presented to the transmitter, stable from tx_start
//   tx_start  : one-cycle start pulse
//   tx_busy   : transmitter busy
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [7:0]          wr_data,
  input  logic                wr_en,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  output logic [7:0]          sdata,
  output logic                tx_start,
  input  logic                tx_busy
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  drain_state_t state, state_nxt;

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;

  // Flags come straight from the registered count, so a push in a full
  // cycle is dropped even if the FSM pops in that same cycle.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign push = wr_en && !full;
  assign pop  = (state == S_IDLE) && !empty && !tx_busy;

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage; the RAM read register is sdata, loaded on the pop edge so the
  // byte is valid in the S_START cycle. A pop never reads the slot written
  // in the same cycle because pop requires a non-empty registered count.
  uart_fifo_mem #(
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (pop),
    .raddr (rd_ptr),
    .rdata (sdata)
  );

  // Drain FSM: state register
  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Drain FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (!empty && !tx_busy) state_nxt = S_START;
      S_START:     state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (tx_busy)  state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (!tx_busy) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Drain FSM: outputs, decoded from the state register only
  always_comb begin
    tx_start = 1'b0;
    if (state == S_START) tx_start = 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. Two instances share clk/rstn: one at
// the default depth and one with DEPTH_LOG2=2 for full/overflow/wrap cases.
// A behavioural transmitter drives tx_busy; a queue model of accepted bytes
// checks order, occupancy, flags and start timing every cycle.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int NI  = 2;
  localparam int DL0 = DEFAULT_DEPTH_LOG2;
  localparam int DL1 = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic       wr_en    [NI];
  logic [7:0] wr_data  [NI];
  logic       tx_busy  [NI];
  logic       full     [NI];
  logic       empty    [NI];
  logic       overflow [NI];
  logic       tx_start [NI];
  logic [7:0] sdata    [NI];
  logic [DL0:0] count0;
  logic [DL1:0] count1;

  uart_tx_fifo #(.DEPTH_LOG2(DL0)) u_dut0 (
    .clk(clk), .rstn(rstn), .wr_data(wr_data[0]), .wr_en(wr_en[0]),
    .full(full[0]), .empty(empty[0]), .count(count0), .overflow(overflow[0]),
    .sdata(sdata[0]), .tx_start(tx_start[0]), .tx_busy(tx_busy[0])
  );

  uart_tx_fifo #(.DEPTH_LOG2(DL1)) u_dut1 (
    .clk(clk), .rstn(rstn), .wr_data(wr_data[1]), .wr_en(wr_en[1]),
    .full(full[1]), .empty(empty[1]), .count(count1), .overflow(overflow[1]),
    .sdata(sdata[1]), .tx_start(tx_start[1]), .tx_busy(tx_busy[1])
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int         depth   [NI];
  logic [7:0] mbuf    [NI][0:1023];
  int         head    [NI];
  int         tail    [NI];
  logic       m_ovf   [NI];
  logic [7:0] last_sd [NI];
  int         starts  [NI];
  int         exp_at  [NI];
  logic       busy_at_edge [NI];
  // transmitter model state
  logic       hold    [NI];
  int         pend    [NI];
  logic       fbusy   [NI];
  int         remain  [NI];
  int         cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_hold(input int i, input logic v);
    hold[i]    = v;
    tx_busy[i] = hold[i] | fbusy[i];
  endtask

  task automatic observe(input int i);
    int cnt;
    int occ;
    cnt = (i == 0) ? int'(count0) : int'(count1);
    if (tx_start[i]) begin
      chk("pop_while_busy", {31'b0, busy_at_edge[i]}, 32'd0);
      chk("start_in_flight", {31'b0, (pend[i] != 0) || fbusy[i]}, 32'd0);
      if (head[i] == tail[i]) begin
        chk("spurious_start", {31'b0, tx_start[i]}, 32'd0);
      end else begin
        chk("sdata_order", {24'b0, sdata[i]}, {24'b0, mbuf[i][head[i] % 1024]});
        last_sd[i] = mbuf[i][head[i] % 1024];
        head[i]++;
        starts[i]++;
      end
    end else begin
      chk("sdata_hold", {24'b0, sdata[i]}, {24'b0, last_sd[i]});
    end
    if (exp_at[i] == cyc) begin
      chk("gap_start", {31'b0, tx_start[i]}, 32'd1);
      exp_at[i] = -1;
    end
    occ = tail[i] - head[i];
    chk("count", cnt, occ);
    chk("full", {31'b0, full[i]}, {31'b0, occ == depth[i]});
    chk("empty", {31'b0, empty[i]}, {31'b0, occ == 0});
    chk("overflow", {31'b0, overflow[i]}, {31'b0, m_ovf[i]});
    // transmitter: busy rises the cycle after tx_start, lasts a random time
    if (tx_start[i]) begin
      pend[i] = 1;
    end else if (pend[i] != 0) begin
      pend[i]   = 0;
      fbusy[i]  = 1'b1;
      remain[i] = $urandom_range(2, 2 * CLK_PER_HALF_BIT);
    end else if (fbusy[i]) begin
      remain[i]--;
      if (remain[i] == 0) begin
        fbusy[i] = 1'b0;
        if (occ > 0 && !hold[i]) exp_at[i] = cyc + 2;
      end
    end
    tx_busy[i] = hold[i] | fbusy[i];
  endtask

  task automatic tick();
    for (int i = 0; i < NI; i++) begin
      busy_at_edge[i] = tx_busy[i];
      if (!rstn) begin
        head[i]    = tail[i];
        m_ovf[i]   = 1'b0;
        pend[i]    = 0;
        fbusy[i]   = 1'b0;
        last_sd[i] = 8'h00;
        exp_at[i]  = -1;
      end else if (wr_en[i]) begin
        if (tail[i] - head[i] < depth[i]) begin
          mbuf[i][tail[i] % 1024] = wr_data[i];
          tail[i]++;
        end else begin
          m_ovf[i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) observe(i);
  endtask

  task automatic push(input int i, input logic [7:0] d);
    wr_en[i]   = 1'b1;
    wr_data[i] = d;
    tick();
    wr_en[i]   = 1'b0;
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while ((tail[i] != head[i] || pend[i] != 0 || fbusy[i]) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_bound", {31'b0, n < 3000}, 32'd1);
    tick();
    tick();
  endtask

  initial begin
    int s0;
    int n;
    for (int i = 0; i < NI; i++) begin
      wr_en[i] = 1'b0; wr_data[i] = 8'h00; tx_busy[i] = 1'b0;
      head[i] = 0; tail[i] = 0; m_ovf[i] = 1'b0; last_sd[i] = 8'h00;
      starts[i] = 0; exp_at[i] = -1; busy_at_edge[i] = 1'b0;
      hold[i] = 1'b0; pend[i] = 0; fbusy[i] = 1'b0; remain[i] = 0;
    end
    depth[0] = 1 << DL0;
    depth[1] = 1 << DL1;

    // reset
    rstn = 1'b0;
    repeat (3) tick();
    chk("rst_tx_start", {31'b0, tx_start[0]}, 32'd0);
    rstn = 1'b1;

    // single byte: push at cycle 10, start exactly two edges later
    repeat (6) tick();
    push(0, 8'hA5);
    chk("single_cnt", {22'b0, count0}, 32'd1);
    tick();
    chk("single_start", {31'b0, tx_start[0]}, 32'd1);
    chk("single_sdata", {24'b0, sdata[0]}, 32'hA5);
    drain(0);

    // burst of 16 consecutive pushes
    s0 = starts[0];
    for (int k = 1; k <= 16; k++) push(0, 8'(k));
    drain(0);
    chk("burst_starts", starts[0] - s0, 32'd16);
    chk("burst_empty", {31'b0, empty[0]}, 32'd1);

    // full / overflow on the 4-deep instance with the transmitter held busy
    set_hold(1, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) push(1, 8'($urandom));
    chk("ovf_full4", {31'b0, full[1]}, 32'd1);
    chk("ovf_not_yet", {31'b0, overflow[1]}, 32'd0);
    push(1, 8'($urandom));
    chk("ovf_set", {31'b0, overflow[1]}, 32'd1);
    chk("ovf_cnt", {29'b0, count1}, 32'd4);
    s0 = starts[1];
    set_hold(1, 1'b0);
    drain(1);
    chk("ovf_drained", starts[1] - s0, 32'd4);
    chk("ovf_sticky", {31'b0, overflow[1]}, 32'd1);

    // pointer wrap: 4 rounds of 3 bytes
    s0 = starts[1];
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) push(1, 8'(16 * r + k + 1));
      drain(1);
    end
    chk("wrap_starts", starts[1] - s0, 32'd12);

    // push in the same cycle as the pop of the only queued byte
    push(0, 8'h3C);
    push(0, 8'hC3);
    chk("simul_start", {31'b0, tx_start[0]}, 32'd1);
    chk("simul_cnt", {22'b0, count0}, 32'd1);
    drain(0);

    // reset while a frame is in flight with 3 bytes queued
    for (int k = 0; k < 4; k++) push(0, 8'($urandom));
    n = 0;
    while (!fbusy[0] && n < 50) begin tick(); n++; end
    chk("midrst_wait", {31'b0, fbusy[0]}, 32'd1);
    tick();
    chk("midrst_queued", {22'b0, count0}, 32'd3);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("midrst_cnt", {22'b0, count0}, 32'd0);
    chk("midrst_start", {31'b0, tx_start[0]}, 32'd0);
    chk("midrst_sdata", {24'b0, sdata[0]}, 32'd0);
    s0 = starts[0];
    repeat (20) tick();
    chk("midrst_quiet", starts[0] - s0, 32'd0);

    // randomized traffic on both instances, with unsolicited busy periods
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < NI; i++) begin
        wr_en[i]   = ($urandom_range(0, 3) == 0);
        wr_data[i] = 8'($urandom);
        if (exp_at[i] < 0 && $urandom_range(0, 39) == 0) set_hold(i, !hold[i]);
      end
      tick();
    end
    for (int i = 0; i < NI; i++) begin
      wr_en[i] = 1'b0;
      set_hold(i, 1'b0);
    end
    drain(0);
    drain(1);
    chk("final_empty0", {31'b0, empty[0]}, 32'd1);
    chk("final_empty1", {31'b0, empty[1]}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer that sits directly upstream of the byte-level UART transmitter.
- The core or MMIO side pushes bytes at full clock rate into a circular FIFO.
- A drain FSM pops one byte at a time and issues a single tx_start pulse per byte.
- The FSM honours the transmitter's tx_busy, so back-to-back core writes never collide with an in-flight frame.

Parameters:
- DEPTH_LOG2, 9, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 bytes.

Ports:
- clk  input  1  system clock
- rstn  input  1  reset
- wr_data  input  8  byte to enqueue
- wr_en  input  1  enqueue strobe; one byte per cycle
- full  output  1  FIFO holds DEPTH bytes
- empty  output  1  FIFO holds 0 bytes
- count  output  DEPTH_LOG2+1  current occupancy
- overflow  output  1  sticky: a write was dropped because FIFO was full
- sdata  output  8  byte presented to transmitter
- tx_start  output  1  one-cycle start pulse to transmitter
- tx_busy  input  1  transmitter busy; rises the cycle after it accepts tx_start and falls after the stop bit

Behaviour:
- Reset: rstn is synchronous, active-low; clock is clk.
  - Reset clears rd_ptr=0, wr_ptr=0, count=0, full=0, empty=1, overflow=0, sdata=8'h00, tx_start=0, state=S_IDLE.
  - Reset mid-frame discards all queued bytes. The transmitter shares rstn, so no partial handshake survives.
- Storage:
  - Circular buffer with DEPTH_LOG2-bit pointers that wrap naturally from DEPTH-1 to 0.
  - count tracks occupancy exactly; full = (count==DEPTH); empty = (count==0), both derived from registered count.
- Push:
  - On wr_en && !full, write mem[wr_ptr] and increment wr_ptr.
  - On wr_en && full, drop the byte, set overflow=1, and leave pointers unchanged. overflow clears only on reset.
  - full is sampled before any same-cycle pop, so a push in a full cycle is dropped even if a pop occurs in that cycle.
- Pop: occurs only on the S_IDLE->S_START transition. It loads sdata<=mem[rd_ptr] and increments rd_ptr.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance.
- Drain FSM states: S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE.
  - S_IDLE: if !empty && !tx_busy, pop and go to S_START; otherwise stay.
  - S_START: tx_start=1 for exactly this cycle, then go to S_WAIT_BUSY.
  - S_WAIT_BUSY: stay until tx_busy==1, then go to S_WAIT_DONE.
  - S_WAIT_DONE: stay until tx_busy==0, then go to S_IDLE.
- Output timing:
  - tx_start is decoded from the state register (state==S_START) and is glitch-free.
  - sdata is held stable from S_START until the next pop.
- Latency and throughput:
  - With an idle FIFO and idle transmitter, wr_en at edge N gives count=1 after N, pop at N+1, and tx_start high in cycle N+2.
  - Inter-frame gap after tx_busy falls is 2 cycles (S_IDLE pop, then S_START).
- Unsolicited busy: if tx_busy is already high in S_IDLE (transmitter busy from another source), no pop occurs.
- Invariant: at most one tx_start per byte. tx_start never asserts while in S_WAIT_BUSY or S_WAIT_DONE.

Decomposition:
- Shared package uart_pkg holds:
  - the drain-state enum (S_IDLE..S_WAIT_DONE, 2 bits);
  - the default CLK_PER_HALF_BIT constant used by both transmitter and bench;
  - the default DEPTH_LOG2.
- Sub-module uart_fifo_mem: simple dual-port byte RAM (write port, registered read) so synthesis infers BRAM. Pointer, count and FSM logic stay in uart_tx_fifo.

Test Plan:
- Single byte: reset, push 8'hA5 at cycle 10 -> tx_start high exactly in cycle 12 with sdata=8'hA5; with a uart_tx instance attached (CLK_PER_HALF_BIT=4), txd shows start bit, 10100101 LSB-first, stop bit.
- Burst: push 8'h01..8'h10 on 16 consecutive cycles -> 16 tx_start pulses, each occurring only after tx_busy fell; bytes emitted in order 01..10; count returns to 0 and empty=1.
- Full/overflow: DEPTH_LOG2=2 with tx_busy held high externally; push 5 bytes -> full=1 after 4 and overflow=1 after the 5th; release tx_busy -> exactly 4 bytes drained and the 5th never appears.
- Wrap-around: DEPTH_LOG2=2; repeatedly push 3 and drain for 4 rounds (12 bytes) -> all 12 bytes emitted in order across pointer wraps.
- Simultaneous push/pop: push in the exact cycle of an S_IDLE pop with count=1 -> count stays 1 and the next byte follows correctly.
- Reset mid-frame: assert rstn=0 for 1 cycle while in S_WAIT_DONE with 3 bytes queued -> next cycle count=0, tx_start=0, state S_IDLE, and no further tx_start until a new push.
